// File: rtl/llc_pipe_hazard_ctrl_pkg.sv
// Shared constants and helpers for the LLC pipeline hazard controller.
// Pipe depth, set width and payload width defaults live here so that both the top and the set matcher agree on them.
package llc_pipe_hazard_ctrl_pkg;

  localparam int LLC_PIPE_STAGES = 4;
  localparam int LLC_SET_BITS    = 9;
  localparam int LLC_PAYLOAD_W   = 16;
  localparam int LLC_STALL_W     = 16;

  // Covers the widest legal pipe (8 stages).
  function automatic logic [3:0] popcount8(input logic [7:0] bits);
    logic [3:0] cnt;
    cnt = '0;
    for (int i = 0; i < 8; i++) begin
      cnt = cnt + 4'(bits[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/llc_set_match.sv
// Parallel set comparators across all pipeline stages, OR-reduced to a single hit.
// Purely combinational, so it never sits on any out_ready path.
module llc_set_match
  import llc_pipe_hazard_ctrl_pkg::*;
#(
  parameter int STAGES   = LLC_PIPE_STAGES,
  parameter int SET_BITS = LLC_SET_BITS
) (
  input  logic [STAGES-1:0]               v,
  input  logic [STAGES-1:0][SET_BITS-1:0] stage_set,
  input  logic [SET_BITS-1:0]             in_set,
  output logic                            hit
);

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < STAGES; i++) begin
      hit = hit | (v[i] && (stage_set[i] == in_set));
    end
  end

endmodule

// File: rtl/llc_pipe_hazard_ctrl.sv
// In-order LLC pipeline controller: STAGES register stages with bubble collapsing,
// set-hazard blocking of new transactions, synchronous flush and a saturating stall counter.
module llc_pipe_hazard_ctrl
  import llc_pipe_hazard_ctrl_pkg::*;
#(
  parameter int STAGES    = LLC_PIPE_STAGES,
  parameter int SET_BITS  = LLC_SET_BITS,
  parameter int PAYLOAD_W = LLC_PAYLOAD_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [SET_BITS-1:0]          in_set,
  input  logic [PAYLOAD_W-1:0]         in_payload,
  input  logic                         in_nohaz,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [SET_BITS-1:0]          out_set,
  output logic [PAYLOAD_W-1:0]         out_payload,
  output logic                         hazard,
  output logic [$clog2(STAGES+1)-1:0]  occupancy,
  output logic [LLC_STALL_W-1:0]       stall_cnt
);

  localparam int OCC_W = $clog2(STAGES+1);

  typedef struct packed {
    logic                 v;
    logic [SET_BITS-1:0]  set;
    logic [PAYLOAD_W-1:0] payload;
  } stage_t;

  stage_t                          stage_q [STAGES];
  stage_t                          stage_d [STAGES];
  logic [STAGES-1:0]               v;
  logic [STAGES-1:0]               v_d;
  logic [STAGES-1:0]               move;
  logic [STAGES-1:0][SET_BITS-1:0] stage_set;
  logic [7:0]                      v_pad;
  logic                            hit;
  logic                            accept;

  always_comb begin
    for (int i = 0; i < STAGES; i++) begin
      v[i]         = stage_q[i].v;
      stage_set[i] = stage_q[i].set;
    end
  end

  llc_set_match #(
    .STAGES   (STAGES),
    .SET_BITS (SET_BITS)
  ) u_set_match (
    .v         (v),
    .stage_set (stage_set),
    .in_set    (in_set),
    .hit       (hit)
  );

  // Walk from the tail: a stage may advance if its successor is empty or itself advancing.
  always_comb begin
    logic can_go;
    logic m;
    move   = '0;
    can_go = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      m       = v[i] && can_go;
      move[i] = m;
      can_go  = !v[i] || m;
    end
  end

  assign hazard   = in_valid && !in_nohaz && hit;
  assign in_ready = rst && (!v[0] || move[0]) && !hazard && !flush;
  assign accept   = in_valid && in_ready;

  always_comb begin
    for (int i = 0; i < STAGES; i++) begin
      stage_d[i] = stage_q[i];
    end
    if (accept) begin
      stage_d[0] = {1'b1, in_set, in_payload};
    end else if (move[0]) begin
      stage_d[0].v = 1'b0;
    end
    for (int i = 1; i < STAGES; i++) begin
      if (move[i-1]) begin
        stage_d[i] = stage_q[i-1];
      end else if (move[i]) begin
        stage_d[i].v = 1'b0;
      end
    end
    // Flush only drops valids; data may still shift since it is ignored without v.
    if (flush) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_d[i].v = 1'b0;
      end
    end
    for (int i = 0; i < STAGES; i++) begin
      v_d[i] = stage_d[i].v;
    end
    v_pad              = '0;
    v_pad[STAGES-1:0]  = v_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
      occupancy <= '0;
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= stage_d[i];
      end
      occupancy <= OCC_W'(popcount8(v_pad));
      if (hazard && !flush && (stall_cnt != {LLC_STALL_W{1'b1}})) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

  assign out_valid   = stage_q[STAGES-1].v;
  assign out_set     = stage_q[STAGES-1].set;
  assign out_payload = stage_q[STAGES-1].payload;

endmodule

// File: tb/tb_llc_pipe_hazard_ctrl.sv
// Directed self-checking bench for llc_pipe_hazard_ctrl with the default 4-stage pipe.
module tb_llc_pipe_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [8:0]  in_set;
  logic [15:0] in_payload;
  logic        in_nohaz;
  logic        out_valid;
  logic        out_ready;
  logic [8:0]  out_set;
  logic [15:0] out_payload;
  logic        hazard;
  logic [2:0]  occupancy;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  llc_pipe_hazard_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_set      (in_set),
    .in_payload  (in_payload),
    .in_nohaz    (in_nohaz),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_set     (out_set),
    .out_payload (out_payload),
    .hazard      (hazard),
    .occupancy   (occupancy),
    .stall_cnt   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [8:0] set, input logic [15:0] payload,
                               input logic nohaz, input logic oready, input logic fl);
    in_valid   = valid;
    in_set     = set;
    in_payload = payload;
    in_nohaz   = nohaz;
    out_ready  = oready;
    flush      = fl;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    int acc;
    rst = 1'b0;
    applyStimulus(1'b1, 9'd7, 16'h0, 1'b0, 1'b1, 1'b0);
    #12;
    checkOutput("reset_in_ready", in_ready, 0);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_occupancy", occupancy, 0);
    checkOutput("reset_stall", stall_cnt, 0);
    checkOutput("reset_out_set", out_set, 0);
    applyStimulus(1'b0, 9'd0, 16'h0, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    tick();

    $display("[TB] in-order streaming of sets 1..4");
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b1, 9'(k), 16'(16'hA0 + k), 1'b0, 1'b1, 1'b0);
      checkOutput("stream_in_ready", in_ready, 1);
      if (k == 4) checkOutput("stream_latency_early", out_valid, 0);
      tick();
    end
    applyStimulus(1'b0, 9'd0, 16'h0, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      checkOutput("stream_out_valid", out_valid, 1);
      checkOutput("stream_out_set", out_set, k);
      checkOutput("stream_out_payload", out_payload, 16'hA0 + k);
      tick();
    end
    checkOutput("stream_drained", out_valid, 0);
    checkOutput("stream_stall", stall_cnt, 0);

    $display("[TB] same-set hazard");
    applyStimulus(1'b1, 9'd5, 16'h55, 1'b0, 1'b1, 1'b0);
    checkOutput("haz_first_ready", in_ready, 1);
    checkOutput("haz_first_hazard", hazard, 0);
    tick();
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b1, 9'd5, 16'h56, 1'b0, 1'b1, 1'b0);
      checkOutput("haz_blocked_hazard", hazard, 1);
      checkOutput("haz_blocked_ready", in_ready, 0);
      tick();
    end
    applyStimulus(1'b1, 9'd5, 16'h56, 1'b0, 1'b1, 1'b0);
    checkOutput("haz_release_hazard", hazard, 0);
    checkOutput("haz_release_ready", in_ready, 1);
    tick();
    applyStimulus(1'b0, 9'd0, 16'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("haz_stall_cnt", stall_cnt, 4);
    for (int k = 0; k < 6; k++) tick();
    checkOutput("haz_drained", occupancy, 0);

    $display("[TB] nohaz bypass");
    applyStimulus(1'b1, 9'd5, 16'h60, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 9'd5, 16'h61, 1'b1, 1'b1, 1'b0);
    checkOutput("nohaz_hazard", hazard, 0);
    checkOutput("nohaz_ready", in_ready, 1);
    tick();
    applyStimulus(1'b1, 9'd5, 16'h62, 1'b0, 1'b1, 1'b0);
    checkOutput("nohaz_entry_blocks", hazard, 1);
    tick();
    applyStimulus(1'b0, 9'd0, 16'h0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) tick();
    checkOutput("nohaz_stall_cnt", stall_cnt, 5);

    $display("[TB] backpressure fill");
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, 9'(10 + k), 16'(16'hB0 + k), 1'b0, 1'b0, 1'b0);
      if (in_ready) acc++;
      tick();
    end
    applyStimulus(1'b1, 9'd15, 16'hB5, 1'b0, 1'b0, 1'b0);
    checkOutput("full_accepts", acc, 4);
    checkOutput("full_occupancy", occupancy, 4);
    checkOutput("full_in_ready", in_ready, 0);
    checkOutput("full_hazard", hazard, 0);
    checkOutput("full_stall_cnt", stall_cnt, 5);
    applyStimulus(1'b1, 9'd15, 16'hB5, 1'b0, 1'b1, 1'b0);
    checkOutput("full_release_ready", in_ready, 1);
    checkOutput("full_head", out_set, 10);
    tick();
    applyStimulus(1'b0, 9'd0, 16'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("full_order_11", out_set, 11);
    tick();
    checkOutput("full_order_12", out_set, 12);
    tick();
    checkOutput("full_order_13", out_set, 13);
    tick();
    checkOutput("full_order_15", out_set, 15);
    checkOutput("full_order_15_pl", out_payload, 16'hB5);
    tick();
    checkOutput("full_drained", out_valid, 0);

    $display("[TB] flush");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 9'(20 + k), 16'(16'hC0 + k), 1'b0, 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b1, 9'd21, 16'hC9, 1'b0, 1'b0, 1'b1);
    checkOutput("flush_pre_occupancy", occupancy, 3);
    checkOutput("flush_in_ready", in_ready, 0);
    tick();
    applyStimulus(1'b1, 9'd21, 16'hC9, 1'b0, 1'b0, 1'b0);
    checkOutput("flush_occupancy", occupancy, 0);
    checkOutput("flush_out_valid", out_valid, 0);
    checkOutput("flush_hazard", hazard, 0);
    checkOutput("flush_reaccept", in_ready, 1);
    tick();
    checkOutput("flush_stall_cnt", stall_cnt, 5);

    $display("[TB] async reset mid-stream");
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b1, 9'(30 + k), 16'(16'hD0 + k), 1'b0, 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 9'd0, 16'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("mid_occupancy", occupancy, 3);
    rst = 1'b0;
    #1;
    checkOutput("arst_occupancy", occupancy, 0);
    checkOutput("arst_out_valid", out_valid, 0);
    checkOutput("arst_stall", stall_cnt, 0);
    checkOutput("arst_out_payload", out_payload, 0);
    rst = 1'b1;
    tick();
    applyStimulus(1'b1, 9'd40, 16'hE0, 1'b0, 1'b1, 1'b0);
    checkOutput("post_rst_ready", in_ready, 1);
    tick();
    applyStimulus(1'b0, 9'd0, 16'h0, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k < 4; k++) begin
      checkOutput("post_rst_wait", out_valid, 0);
      tick();
    end
    checkOutput("post_rst_valid", out_valid, 1);
    checkOutput("post_rst_set", out_set, 40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
